deci_entry: RTL

Keypad-side decimal-to-binary converter for the calculator: it collects up to three decimal digits plus a sign and converts the result into a signed two's-complement operand. It is the inverse of the display path, which converts the accumulator into sign plus hundreds/tens/ones. Conversion is sequential, by repeated addition of 100 and 10, and saturates on out-of-range entries. The result feeds the ALU operand register, and the live BCD entry feeds the hex displays while the user types.

---
 rtl/calc_pkg.sv | 16 +
 rtl/bcd_entry_reg.sv | 43 ++++
 rtl/deci_entry.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types and decimal-entry constants
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUND,
        TENS,
        ONES,
        DONE
    } deci_entry_state_t;

    localparam int DEC_HUNDRED  = 100;
    localparam int DEC_TEN      = 10;
    localparam int ENTRY_DIGITS = 3;

endpackage

// File: rtl/bcd_entry_reg.sv
// rtl/bcd_entry_reg.sv - three-digit BCD shift register with sign bit
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_i,
    input  logic [3:0]  digit_i,
    input  logic        toggle_i,
    input  logic        clear_i,
    output logic [11:0] bcd_o,
    output logic        neg_o
);

    logic [11:0] bcd_q;
    logic [1:0]  count_q;
    logic        neg_q;

    // Shift digits in from the ones end until three have been taken; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= 12'h000;
            count_q <= 2'd0;
            neg_q   <= 1'b0;
        end else if (clear_i) begin
            bcd_q   <= 12'h000;
            count_q <= 2'd0;
            neg_q   <= 1'b0;
        end else begin
            if (shift_i && (count_q < 2'(ENTRY_DIGITS))) begin
                bcd_q   <= {bcd_q[7:0], digit_i};
                count_q <= count_q + 2'd1;
            end
            if (toggle_i) begin
                neg_q <= ~neg_q;
            end
        end
    end

    assign bcd_o = bcd_q;
    assign neg_o = neg_q;

endmodule

// File: rtl/deci_entry.sv
// rtl/deci_entry.sv - keypad decimal entry to saturating two's-complement operand
module deci_entry
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         digit_valid,
    input  logic [3:0]   digit,
    input  logic         neg_toggle,
    input  logic         clear,
    input  logic         enter,
    output logic [11:0]  entry_bcd,
    output logic         entry_neg,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         done
);

    localparam logic [10:0] MAX_POS_MAG = 11'((1 << (W - 1)) - 1);
    localparam logic [10:0] MAX_NEG_MAG = 11'(1 << (W - 1));

    deci_entry_state_t state_q;
    logic [9:0]        acc_q;
    logic [3:0]        hcnt_q;
    logic [3:0]        tcnt_q;
    logic [W-1:0]      result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              done_q;

    logic              idle;
    logic              entry_shift;
    logic              entry_toggle;
    logic              entry_clear;
    logic [11:0]       bcd;
    logic              neg;
    logic [10:0]       acc_ext;
    logic [10:0]       acc_negated;

    assign idle = (state_q == IDLE);

    // Keypad edits only land while idle and when neither clear nor enter claims the cycle.
    assign entry_shift  = idle && digit_valid && (digit <= 4'd9) && !clear && !enter;
    assign entry_toggle = idle && neg_toggle && !clear && !enter;
    assign entry_clear  = clear || (state_q == DONE);

    bcd_entry_reg u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_i  (entry_shift),
        .digit_i  (digit),
        .toggle_i (entry_toggle),
        .clear_i  (entry_clear),
        .bcd_o    (bcd),
        .neg_o    (neg)
    );

    // Range check of the accumulated magnitude against the signed W-bit limits.
    always_comb begin
        acc_ext     = {1'b0, acc_q};
        acc_negated = 11'd0 - acc_ext;
        result_d    = acc_ext[W-1:0];
        ovf_d       = 1'b0;
        if (!neg && (acc_ext > MAX_POS_MAG)) begin
            result_d = {1'b0, {(W - 1){1'b1}}};
            ovf_d    = 1'b1;
        end else if (neg && (acc_ext > MAX_NEG_MAG)) begin
            result_d = {1'b1, {(W - 1){1'b0}}};
            ovf_d    = 1'b1;
        end else if (neg) begin
            result_d = acc_negated[W-1:0];
        end
    end

    // Conversion FSM: add hundreds, then tens, then ones, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= 10'd0;
            hcnt_q   <= 4'd0;
            tcnt_q   <= 4'd0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (enter) begin
                            acc_q   <= 10'd0;
                            hcnt_q  <= bcd[11:8];
                            tcnt_q  <= bcd[7:4];
                            state_q <= HUND;
                        end
                    end
                    HUND: begin
                        if (hcnt_q != 4'd0) begin
                            acc_q  <= acc_q + 10'(DEC_HUNDRED);
                            hcnt_q <= hcnt_q - 4'd1;
                        end else begin
                            state_q <= TENS;
                        end
                    end
                    TENS: begin
                        if (tcnt_q != 4'd0) begin
                            acc_q  <= acc_q + 10'(DEC_TEN);
                            tcnt_q <= tcnt_q - 4'd1;
                        end else begin
                            state_q <= ONES;
                        end
                    end
                    ONES: begin
                        acc_q   <= acc_q + {6'd0, bcd[3:0]};
                        state_q <= DONE;
                    end
                    DONE: begin
                        result_q <= result_d;
                        ovf_q    <= ovf_d;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign entry_bcd = bcd;
    assign entry_neg = neg;
    assign busy      = !idle;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign done      = done_q;

endmodule
